// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency external pipe among N_REQ requesters.
// Tracks the owner of each in-flight slot and steers the pipe result back to it.
module pipe_rr_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*W-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               pipe_valid_o,
  output logic [W-1:0]       pipe_d_o,
  input  logic [W-1:0]       pipe_q_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [W-1:0]       rsp_data_o
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  logic [PtrW-1:0]             ptr_q, ptr_d;
  logic [N_REQ-1:0][CntW-1:0]  outst_q, outst_d;
  logic [N_REQ-1:0]            elig;
  logic [N_REQ-1:0]            inc;
  logic                        xfer;
  logic [PtrW-1:0]             gnt_idx;
  logic [LATENCY:0]            tag_vld_q;
  logic [LATENCY:0][PtrW-1:0]  tag_id_q;

  // Eligibility sees only the registered count: a returning response frees
  // its credit one cycle later, keeping pipe_q off the grant path.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid_i[i] && (outst_q[i] < CntW'(MAX_OUTST));
    end
  end

  always_comb begin
    int unsigned idx;
    idx         = 0;
    req_ready_o = '0;
    gnt_idx     = '0;
    xfer        = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!xfer && elig[idx]) begin
        req_ready_o[idx] = 1'b1;
        gnt_idx          = PtrW'(idx);
        xfer             = 1'b1;
      end
    end
  end

  assign inc   = req_ready_o & req_valid_i;
  assign ptr_d = xfer ? PtrW'((32'(gnt_idx) + 1) % N_REQ) : ptr_q;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (tag_vld_q[LATENCY] && (tag_id_q[LATENCY] == PtrW'(i))) rsp_valid_o[i] = 1'b1;
    end
  end

  assign rsp_data_o = pipe_q_i;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      outst_d[i] = outst_q[i];
      if (inc[i] && !rsp_valid_o[i]) begin
        outst_d[i] = outst_q[i] + CntW'(1);
      end else if (rsp_valid_o[i] && !inc[i]) begin
        outst_d[i] = outst_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      outst_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      pipe_valid_o <= 1'b0;
      pipe_d_o     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      outst_q      <= outst_d;
      tag_vld_q    <= {tag_vld_q[LATENCY-1:0], xfer};
      tag_id_q     <= {tag_id_q[LATENCY-1:0], gnt_idx};
      pipe_valid_o <= xfer;
      if (xfer) pipe_d_o <= req_data_i[32'(gnt_idx)*W +: W];
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      !(inc[g] && !rsp_valid_o[g] && (outst_q[g] == CntW'(MAX_OUTST))))
      else $error("outstanding counter overflow on requester %0d", g);
    assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_valid_o[g] && !inc[g] && (outst_q[g] == '0)))
      else $error("outstanding counter underflow on requester %0d", g);
  end

endmodule
